posicionador_embarcacao: RTL



---
 rtl/posicionador_embarcacao_pkg.sv | 22 ++
 rtl/posicionador_embarcacao_empacota_celulas.sv | 36 +++
 rtl/posicionador_embarcacao.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/posicionador_embarcacao_pkg.sv
// Shared definitions for ship placement and the VGA ship drawers:
// controller state encoding, board geometry and the packed-vector field layout.
package posicionador_embarcacao_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        MOVENDO  = 2'd1,
        VERIFICA = 2'd2,
        FIXADO   = 2'd3
    } estado_t;

    localparam int TAM_TABULEIRO = 8;
    localparam int OFFSET_X      = 6;
    localparam int OFFSET_Y      = 10;
    localparam int PASSO_CELULA  = 8;

    // Board cell (X,Y), both 1-based, to its bit in the 64-bit occupancy map.
    function automatic logic [5:0] indice_celula(input logic [3:0] x, input logic [3:0] y);
        return (({2'b00, y} - 6'd1) * 6'(TAM_TABULEIRO)) + ({2'b00, x} - 6'd1);
    endfunction

endpackage

// File: rtl/posicionador_embarcacao_empacota_celulas.sv
// empacota_celulas: purely combinational ship layout. From the anchor, the
// orientation and the ship length it builds the packed coordinate vector and
// the 64-bit mask of the cells the ship covers.
module empacota_celulas
    import posicionador_embarcacao_pkg::*;
#(
    parameter int TAMANHO = 5
) (
    input  logic [3:0]  x0_i,
    input  logic [3:0]  y0_i,
    input  logic        vertical_i,
    output logic [63:0] vetor_o,
    output logic [63:0] mascara_o
);

    // Walk the ship cells from the anchor; cells beyond TAMANHO stay zero.
    always_comb begin
        logic [3:0] cx;
        logic [3:0] cy;
        cx        = '0;
        cy        = '0;
        vetor_o   = '0;
        mascara_o = '0;
        vetor_o[2:0] = 3'(TAMANHO);
        for (int k = 0; k < 5; k++) begin
            if (k < TAMANHO) begin
                cx = vertical_i ? x0_i : x0_i + 4'(k);
                cy = vertical_i ? y0_i + 4'(k) : y0_i;
                vetor_o[OFFSET_X + PASSO_CELULA*k -: 4] = cx;
                vetor_o[OFFSET_Y + PASSO_CELULA*k -: 4] = cy;
                mascara_o[indice_celula(cx, cy)]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posicionador_embarcacao.sv
// posicionador_embarcacao: interactive placement of one ship on the 8x8 board.
// Button pulses move/rotate the anchor inside the board; confirm commits it.
// Build option POSICIONADOR_COLISAO_EN: when defined, confirm first walks the
// ship cells against `ocupacao` one per cycle (VERIFICA) and reports a
// collision on `erro`; when undefined, confirm commits immediately.
// All outputs are registered one cycle behind the controller state.
module posicionador_embarcacao
    import posicionador_embarcacao_pkg::*;
#(
    parameter int TAMANHO = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilitar,
    input  logic        btn_cima,
    input  logic        btn_baixo,
    input  logic        btn_esq,
    input  logic        btn_dir,
    input  logic        btn_girar,
    input  logic        btn_confirmar,
    input  logic [63:0] ocupacao,
    output logic [63:0] posicoesEmbarcacao,
    output logic [63:0] ocupacao_nova,
    output logic        posicionada,
    output logic        erro,
    output logic        ocupado
);

    localparam logic [3:0] MAX_LONGO = 4'(9 - TAMANHO);
    localparam logic [3:0] MAX_CURTO = 4'(TAM_TABULEIRO);

    estado_t     estado_q, estado_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic        vertical_q, vertical_d;
    logic [3:0]  lim_x, lim_y;
    logic [63:0] vetor, mascara;
    logic [63:0] posicoes_q, ocupacao_nova_q;
    logic        posicionada_q, erro_q, ocupado_q;
    logic        ocupado_prox, erro_prox;

    empacota_celulas #(.TAMANHO(TAMANHO)) u_empacota (
        .x0_i       (x_q),
        .y0_i       (y_q),
        .vertical_i (vertical_q),
        .vetor_o    (vetor),
        .mascara_o  (mascara)
    );

    // The long axis is the one the ship extends along.
    assign lim_x = vertical_q ? MAX_CURTO : MAX_LONGO;
    assign lim_y = vertical_q ? MAX_LONGO : MAX_CURTO;

`ifdef POSICIONADOR_COLISAO_EN
    localparam logic [2:0] ULTIMA = 3'(TAMANHO - 1);

    logic [2:0] cont_q, cont_d;
    logic       colisao_q, colisao_d;
    logic       erro_evt_q, erro_evt_d;
    logic [3:0] cx_teste, cy_teste;
    logic       acerto;

    // Cell under test this cycle; ocupacao is sampled live, never latched.
    assign cx_teste     = vertical_q ? x_q : x_q + {1'b0, cont_q};
    assign cy_teste     = vertical_q ? y_q + {1'b0, cont_q} : y_q;
    assign acerto       = ocupacao[indice_celula(cx_teste, cy_teste)];
    assign ocupado_prox = (estado_q == VERIFICA);
    assign erro_prox    = erro_evt_q;
`else
    logic unused_ocupacao;
    assign unused_ocupacao = ^ocupacao;
    assign ocupado_prox    = 1'b0;
    assign erro_prox       = 1'b0;
`endif

    // Next-state: one action per cycle, confirm > rotate > up > down > left > right.
    always_comb begin
        estado_d   = estado_q;
        x_d        = x_q;
        y_d        = y_q;
        vertical_d = vertical_q;
`ifdef POSICIONADOR_COLISAO_EN
        cont_d     = cont_q;
        colisao_d  = colisao_q;
        erro_evt_d = 1'b0;
`endif
        case (estado_q)
            OCIOSO, FIXADO: begin
                if (habilitar) begin
                    estado_d   = MOVENDO;
                    x_d        = 4'd1;
                    y_d        = 4'd1;
                    vertical_d = 1'b0;
                end
            end
            MOVENDO: begin
                if (btn_confirmar) begin
`ifdef POSICIONADOR_COLISAO_EN
                    estado_d  = VERIFICA;
                    cont_d    = 3'd0;
                    colisao_d = 1'b0;
`else
                    estado_d  = FIXADO;
`endif
                end else if (btn_girar) begin
                    vertical_d = !vertical_q;
                    // After the toggle the other axis becomes the long one.
                    if (vertical_q) begin
                        if (x_q > MAX_LONGO) x_d = MAX_LONGO;
                    end else begin
                        if (y_q > MAX_LONGO) y_d = MAX_LONGO;
                    end
                end else if (btn_cima) begin
                    if (y_q < lim_y) y_d = y_q + 4'd1;
                end else if (btn_baixo) begin
                    if (y_q > 4'd1) y_d = y_q - 4'd1;
                end else if (btn_esq) begin
                    if (x_q > 4'd1) x_d = x_q - 4'd1;
                end else if (btn_dir) begin
                    if (x_q < lim_x) x_d = x_q + 4'd1;
                end
            end
            VERIFICA: begin
`ifdef POSICIONADOR_COLISAO_EN
                colisao_d = colisao_q | acerto;
                cont_d    = cont_q + 3'd1;
                if (cont_q == ULTIMA) begin
                    if (colisao_q | acerto) begin
                        estado_d   = MOVENDO;
                        erro_evt_d = 1'b1;
                    end else begin
                        estado_d   = FIXADO;
                    end
                end
`else
                estado_d = OCIOSO;
`endif
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Controller state and anchor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            x_q        <= 4'd1;
            y_q        <= 4'd1;
            vertical_q <= 1'b0;
`ifdef POSICIONADOR_COLISAO_EN
            cont_q     <= 3'd0;
            colisao_q  <= 1'b0;
            erro_evt_q <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vertical_q <= vertical_d;
`ifdef POSICIONADOR_COLISAO_EN
            cont_q     <= cont_d;
            colisao_q  <= colisao_d;
            erro_evt_q <= erro_evt_d;
`endif
        end
    end

    // Output registers: a one-cycle delayed view of the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            posicoes_q      <= '0;
            ocupacao_nova_q <= '0;
            posicionada_q   <= 1'b0;
            erro_q          <= 1'b0;
            ocupado_q       <= 1'b0;
        end else begin
            posicoes_q      <= (estado_q == OCIOSO) ? '0 : vetor;
            ocupacao_nova_q <= (estado_q == FIXADO) ? mascara : '0;
            posicionada_q   <= (estado_q == FIXADO);
            erro_q          <= erro_prox;
            ocupado_q       <= ocupado_prox;
        end
    end

    assign posicoesEmbarcacao = posicoes_q;
    assign ocupacao_nova      = ocupacao_nova_q;
    assign posicionada        = posicionada_q;
    assign erro               = erro_q;
    assign ocupado            = ocupado_q;

endmodule
